imm_field_encoder: RTL and testbench
====================================

Name: imm_field_encoder

Overview:
- Inverse of the datapath immediate sign-extension path: packs a 16-bit value into the instruction immediate fields for the loader/assembler-assist path feeding instruction memory.
- General immediates go into the 11-bit field; branch byte-offsets go into the 13-bit field, right-shifted by one.
- A general value that does not fit 11 bits is split into two words, HI then LO.
- Uses a valid/ready handshake on both sides. One word is emitted per accepted handshake.

Parameters:
- DATA_W, 16, input value width.
- IMM_W, 11, general immediate field width.
- BR_W, 13, branch field width (halfword offset).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input value offered.
- in_ready  out  1  encoder can accept; high only in IDLE.
- in_value  in  DATA_W  value to encode (immediate, or branch byte offset).
- in_is_branch  in  1  1 = branch encoding, 0 = general immediate.
- out_valid  out  1  out_field/out_kind/out_err valid.
- out_ready  in  1  consumer accepts the current word.
- out_field  out  BR_W  encoded field, zero-padded above the used width.
- out_kind  out  2  0 = IMM, 1 = HI, 2 = LO, 3 = BR.
- out_err  out  1  value not encodable.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high.
- Reset values:
  - out_valid = 0, out_field = 0, out_kind = 0, out_err = 0.
  - State = IDLE, so in_ready = 1 in the first cycle after reset.
  - Internal value register = 0.
- States: IDLE, EMIT_ONE, EMIT_HI, EMIT_LO.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid = 1 and out_ready = 0, all out_* signals hold stable.
  - in_ready is combinational from state: in_ready = (state == IDLE).
- Latency: a value accepted at edge N drives out_valid = 1 from cycle N+1. With no backpressure, IDLE is re-entered one cycle after the final output transfer. Throughput is one value per 2 cycles (single word) or 3 cycles (split).
- Fit rules, evaluated at acceptance:
  - Immediate fits iff in_value[15:10] are all equal.
  - Branch fits iff in_value[0] = 0 and in_value[15:13] are all equal.
- IDLE on input transfer:
  - Branch that fits → EMIT_ONE; kind = BR, field = in_value[13:1], err = 0.
  - Branch that does not fit → EMIT_ONE; kind = BR, field = 0, err = 1.
  - Immediate that fits → EMIT_ONE; kind = IMM, field = zero-padded in_value[10:0], err = 0.
  - Immediate that does not fit → EMIT_HI; field = in_value[15:8].
- EMIT_ONE on output transfer → IDLE.
- EMIT_HI on output transfer → EMIT_LO; field = zero-extended in_value[7:0], kind = LO.
- EMIT_LO on output transfer → IDLE.
- Round-trip property: for every value that fits, sign-extending out_field (shifting left by one for BR) reproduces in_value exactly.
- Boundary values:
  - 0x03FF and 0xFC00 fit as IMM.
  - 0x0400 splits.
  - 0x1FFE and 0xE000 fit as BR.
  - 0x2000 errors.
- Reset has priority over every transition. Reset mid-split drops the pending LO word; no partial state is retained.
- in_value / in_is_branch are ignored when not accepted.

Optional Feature:
- Macro: IMM_ENC_STATS_EN.
- When defined, adds three outputs:
  - stat_split [7:0]: counts accepted split immediates.
  - stat_err [7:0]: counts errored branches.
  - stat_clr in [1]: synchronous clear.
- Counters saturate at 0xFF, clear on Reset or stat_clr, and increment at input acceptance.
- When undefined, these ports and registers do not exist. Encoding behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - KIND_IMM/KIND_HI/KIND_LO/KIND_BR 2-bit constants.
  - State encodings.
  - DATA_W/IMM_W/BR_W defaults, shared with the datapath sign-extender.
- One natural combinational sub-module: imm_fit_check (value, is_branch → fits, field). Reused by verification as a reference check.

Test Plan:
- IMM 0x03FF, then 0xFC00, out_ready = 1 → single IMM words with field 0x3FF then 0x400, err = 0, out_valid one cycle after accept.
- IMM 0x1234 → HI field 0x012, then LO field 0x034; in_ready low until the cycle after LO transfers.
- BR 0xFFFE → BR field 0x1FFF, err = 0; BR 0x0003 → BR, field 0, err = 1; BR 0x2000 → err = 1.
- 0x8000 split with out_ready low 3 cycles during HI → HI (0x080) held stable, then LO 0x000; in_ready stays 0 throughout.
- Reset asserted while in EMIT_LO → next cycle out_valid = 0, in_ready = 1, no LO word ever transferred.
- IMM_ENC_STATS_EN: 300 split immediates + 2 errored branches → stat_split = 0xFF, stat_err = 0x02; stat_clr → both 0.

Source files
------------

// File: rtl/imm_field_encoder_pkg.sv
// -----------------------------------------------------------------------------
// imm_field_encoder_pkg
// Shared definitions for the immediate field encoder and the datapath
// sign-extender: field widths, output word kinds, FSM state encodings and a
// saturating counter helper.
// -----------------------------------------------------------------------------
package imm_field_encoder_pkg;

    localparam int DATA_W = 16;  // input value width
    localparam int IMM_W  = 11;  // general immediate field width
    localparam int BR_W   = 13;  // branch field width (halfword offset)

    // Kind tag carried alongside every emitted word
    localparam logic [1:0] KIND_IMM = 2'd0;
    localparam logic [1:0] KIND_HI  = 2'd1;
    localparam logic [1:0] KIND_LO  = 2'd2;
    localparam logic [1:0] KIND_BR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EMIT_ONE = 2'd1,
        ST_EMIT_HI  = 2'd2,
        ST_EMIT_LO  = 2'd3
    } enc_state_e;

    // 8-bit increment that sticks at 0xFF instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
        if (cnt == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = cnt + 8'd1;
        end
    endfunction

endpackage : imm_field_encoder_pkg

// File: rtl/imm_fit_check.sv
// -----------------------------------------------------------------------------
// imm_fit_check
// Combinational fit test and first-word field formation for one value.
//   value_i     : value to encode (immediate or branch byte offset)
//   is_branch_i : 1 = branch encoding, 0 = general immediate
//   fits_o      : value is representable in the selected field
//   field_o     : first word field, zero-padded to BR_W bits
//                 (BR offset, IMM field, HI byte of a split, or 0 on BR error)
// -----------------------------------------------------------------------------
module imm_fit_check
    import imm_field_encoder_pkg::*;
(
    input  logic [DATA_W-1:0] value_i,
    input  logic              is_branch_i,
    output logic              fits_o,
    output logic [BR_W-1:0]   field_o
);

    logic imm_fits_s;
    logic br_fits_s;

    // Bits above the sign bit must all copy it for sign-extension to round-trip
    assign imm_fits_s = (&value_i[DATA_W-1:IMM_W-1]) | ~(|value_i[DATA_W-1:IMM_W-1]);
    // Branch offsets are halfword aligned and the dropped LSB must be zero
    assign br_fits_s  = ~value_i[0] &
                        ((&value_i[DATA_W-1:BR_W]) | ~(|value_i[DATA_W-1:BR_W]));

    // Select fit result and first-word field for the requested encoding
    always_comb begin
        fits_o  = 1'b0;
        field_o = {BR_W{1'b0}};
        if (is_branch_i) begin
            fits_o = br_fits_s;
            if (br_fits_s) begin
                field_o = value_i[BR_W:1];
            end else begin
                field_o = {BR_W{1'b0}};
            end
        end else begin
            fits_o = imm_fits_s;
            if (imm_fits_s) begin
                field_o = {{(BR_W-IMM_W){1'b0}}, value_i[IMM_W-1:0]};
            end else begin
                field_o = {{(BR_W-8){1'b0}}, value_i[DATA_W-1:8]};
            end
        end
    end

endmodule : imm_fit_check

// File: rtl/imm_field_encoder.sv
// -----------------------------------------------------------------------------
// imm_field_encoder
// Packs a 16-bit value into instruction immediate fields (inverse of the
// datapath sign-extender). General immediates use the 11-bit field; a value
// that does not fit is split into a HI word then a LO word. Branch byte
// offsets use the 13-bit field, shifted right by one.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset
//   in_valid_i     input value offered
//   in_ready_o     encoder can accept (only in IDLE)
//   in_value_i     value to encode
//   in_is_branch_i 1 = branch encoding, 0 = general immediate
//   out_valid_o    out_field_o/out_kind_o/out_err_o valid
//   out_ready_i    consumer accepts the current word
//   out_field_o    encoded field, zero-padded
//   out_kind_o     0 = IMM, 1 = HI, 2 = LO, 3 = BR
//   out_err_o      value not encodable
// Optional (macro IMM_ENC_STATS_EN):
//   stat_clr_i     synchronous clear of the statistics counters
//   stat_split_o   saturating count of accepted split immediates
//   stat_err_o     saturating count of errored branches
// -----------------------------------------------------------------------------
module imm_field_encoder
    import imm_field_encoder_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_value_i,
    input  logic              in_is_branch_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [BR_W-1:0]   out_field_o,
    output logic [1:0]        out_kind_o,
`ifdef IMM_ENC_STATS_EN
    input  logic              stat_clr_i,
    output logic [7:0]        stat_split_o,
    output logic [7:0]        stat_err_o,
`endif
    output logic              out_err_o
);

    enc_state_e      state_q, state_d;
    logic [7:0]      lo_byte_q, lo_byte_d;   // pending LO byte of a split
    logic            valid_q, valid_d;
    logic [BR_W-1:0] field_q, field_d;
    logic [1:0]      kind_q, kind_d;
    logic            err_q, err_d;

    logic            fits_s;
    logic [BR_W-1:0] first_field_s;
    logic            accept_s;
    logic            out_xfer_s;

    imm_fit_check u_fit (
        .value_i     (in_value_i),
        .is_branch_i (in_is_branch_i),
        .fits_o      (fits_s),
        .field_o     (first_field_s)
    );

    assign in_ready_o  = (state_q == ST_IDLE);
    assign accept_s    = in_valid_i && in_ready_o;
    assign out_xfer_s  = valid_q && out_ready_i;

    assign out_valid_o = valid_q;
    assign out_field_o = field_q;
    assign out_kind_o  = kind_q;
    assign out_err_o   = err_q;

    // Next-state and next-output logic; outputs hold unless a transfer occurs
    always_comb begin
        state_d   = state_q;
        lo_byte_d = lo_byte_q;
        valid_d   = valid_q;
        field_d   = field_q;
        kind_d    = kind_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    lo_byte_d = in_value_i[7:0];
                    valid_d   = 1'b1;
                    field_d   = first_field_s;
                    if (in_is_branch_i) begin
                        kind_d  = KIND_BR;
                        err_d   = ~fits_s;
                        state_d = ST_EMIT_ONE;
                    end else if (fits_s) begin
                        kind_d  = KIND_IMM;
                        err_d   = 1'b0;
                        state_d = ST_EMIT_ONE;
                    end else begin
                        kind_d  = KIND_HI;
                        err_d   = 1'b0;
                        state_d = ST_EMIT_HI;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_EMIT_ONE: begin
                if (out_xfer_s) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EMIT_ONE;
                end
            end
            ST_EMIT_HI: begin
                if (out_xfer_s) begin
                    field_d = {{(BR_W-8){1'b0}}, lo_byte_q};
                    kind_d  = KIND_LO;
                    err_d   = 1'b0;
                    state_d = ST_EMIT_LO;
                end else begin
                    state_d = ST_EMIT_HI;
                end
            end
            ST_EMIT_LO: begin
                if (out_xfer_s) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EMIT_LO;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered output word; reset discards any pending LO word
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            lo_byte_q <= 8'h00;
            valid_q   <= 1'b0;
            field_q   <= {BR_W{1'b0}};
            kind_q    <= KIND_IMM;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_byte_q <= lo_byte_d;
            valid_q   <= valid_d;
            field_q   <= field_d;
            kind_q    <= kind_d;
            err_q     <= err_d;
        end
    end

`ifdef IMM_ENC_STATS_EN
    logic [7:0] stat_split_q;
    logic [7:0] stat_err_q;

    // Saturating event counters sampled at input acceptance; clear wins
    always_ff @(posedge clk_i) begin
        if (reset_i || stat_clr_i) begin
            stat_split_q <= 8'h00;
            stat_err_q   <= 8'h00;
        end else begin
            if (accept_s && !in_is_branch_i && !fits_s) begin
                stat_split_q <= sat_inc8(stat_split_q);
            end else begin
                stat_split_q <= stat_split_q;
            end
            if (accept_s && in_is_branch_i && !fits_s) begin
                stat_err_q <= sat_inc8(stat_err_q);
            end else begin
                stat_err_q <= stat_err_q;
            end
        end
    end

    assign stat_split_o = stat_split_q;
    assign stat_err_o   = stat_err_q;
`endif

endmodule : imm_field_encoder

// File: tb/tb_imm_field_encoder.sv
// -----------------------------------------------------------------------------
// tb_imm_field_encoder
// Directed vectors with hand-computed expected words for imm_field_encoder.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_imm_field_encoder;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] in_value_i;
    logic        in_is_branch_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [12:0] out_field_o;
    logic [1:0]  out_kind_o;
    logic        out_err_o;
`ifdef IMM_ENC_STATS_EN
    logic        stat_clr_i;
    logic [7:0]  stat_split_o;
    logic [7:0]  stat_err_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [1:0] K_IMM = 2'd0;
    localparam logic [1:0] K_HI  = 2'd1;
    localparam logic [1:0] K_LO  = 2'd2;
    localparam logic [1:0] K_BR  = 2'd3;

    imm_field_encoder dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_value_i     (in_value_i),
        .in_is_branch_i (in_is_branch_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_field_o    (out_field_o),
        .out_kind_o     (out_kind_o),
`ifdef IMM_ENC_STATS_EN
        .stat_clr_i     (stat_clr_i),
        .stat_split_o   (stat_split_o),
        .stat_err_o     (stat_err_o),
`endif
        .out_err_o      (out_err_o)
    );

    // Free-running clock, 10 time units per period
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one value for a single cycle; called at a falling edge in IDLE
    task automatic accept(input string tag, input logic [15:0] v, input logic br);
        check({tag, ".in_ready"}, {15'd0, in_ready_o}, 16'd1);
        in_valid_i     = 1'b1;
        in_value_i     = v;
        in_is_branch_i = br;
        @(negedge clk_i);
        in_valid_i     = 1'b0;
        in_value_i     = 16'hDEAD;   // must be ignored when not accepted
        in_is_branch_i = ~br;
    endtask

    // Check the current word and let it transfer (out_ready held high)
    task automatic expect_word(input string tag, input logic [1:0] kind,
                               input logic [12:0] field, input logic err);
        check({tag, ".valid"}, {15'd0, out_valid_o}, 16'd1);
        check({tag, ".kind"},  {14'd0, out_kind_o},  {14'd0, kind});
        check({tag, ".field"}, {3'd0, out_field_o},  {3'd0, field});
        check({tag, ".err"},   {15'd0, out_err_o},   {15'd0, err});
        check({tag, ".busy"},  {15'd0, in_ready_o},  16'd0);
        @(negedge clk_i);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".idle_valid"}, {15'd0, out_valid_o}, 16'd0);
        check({tag, ".idle_ready"}, {15'd0, in_ready_o},  16'd1);
    endtask

    initial begin
        reset_i        = 1'b1;
        in_valid_i     = 1'b0;
        in_value_i     = 16'h0000;
        in_is_branch_i = 1'b0;
        out_ready_i    = 1'b1;
`ifdef IMM_ENC_STATS_EN
        stat_clr_i     = 1'b0;
`endif
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;

        // Reset state
        check("rst.valid", {15'd0, out_valid_o}, 16'd0);
        check("rst.field", {3'd0, out_field_o},  16'd0);
        check("rst.kind",  {14'd0, out_kind_o},  16'd0);
        check("rst.err",   {15'd0, out_err_o},   16'd0);
        check("rst.ready", {15'd0, in_ready_o},  16'd1);

        // Immediate boundaries: single IMM words, valid the cycle after accept
        accept("imm3ff", 16'h03FF, 1'b0);
        expect_word("imm3ff", K_IMM, 13'h03FF, 1'b0);
        expect_idle("imm3ff");
        accept("immfc00", 16'hFC00, 1'b0);
        expect_word("immfc00", K_IMM, 13'h0400, 1'b0);
        expect_idle("immfc00");

        // Split immediate: HI then LO, in_ready low until after LO
        accept("s1234", 16'h1234, 1'b0);
        expect_word("s1234.hi", K_HI, 13'h0012, 1'b0);
        expect_word("s1234.lo", K_LO, 13'h0034, 1'b0);
        expect_idle("s1234");
        accept("s0400", 16'h0400, 1'b0);
        expect_word("s0400.hi", K_HI, 13'h0004, 1'b0);
        expect_word("s0400.lo", K_LO, 13'h0000, 1'b0);
        expect_idle("s0400");

        // Branch encodings and errors
        accept("brfffe", 16'hFFFE, 1'b1);
        expect_word("brfffe", K_BR, 13'h1FFF, 1'b0);
        expect_idle("brfffe");
        accept("br0003", 16'h0003, 1'b1);
        expect_word("br0003", K_BR, 13'h0000, 1'b1);
        expect_idle("br0003");
        accept("br2000", 16'h2000, 1'b1);
        expect_word("br2000", K_BR, 13'h0000, 1'b1);
        expect_idle("br2000");
        accept("br1ffe", 16'h1FFE, 1'b1);
        expect_word("br1ffe", K_BR, 13'h0FFF, 1'b0);
        expect_idle("br1ffe");
        accept("bre000", 16'hE000, 1'b1);
        expect_word("bre000", K_BR, 13'h1000, 1'b0);
        expect_idle("bre000");

        // Backpressure on HI: word holds stable, in_ready stays low
        out_ready_i = 1'b0;
        accept("s8000", 16'h8000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("s8000.hold_valid", {15'd0, out_valid_o}, 16'd1);
            check("s8000.hold_kind",  {14'd0, out_kind_o},  {14'd0, K_HI});
            check("s8000.hold_field", {3'd0, out_field_o},  16'h0080);
            check("s8000.hold_busy",  {15'd0, in_ready_o},  16'd0);
            @(negedge clk_i);
        end
        out_ready_i = 1'b1;
        expect_word("s8000.hi", K_HI, 13'h0080, 1'b0);
        expect_word("s8000.lo", K_LO, 13'h0000, 1'b0);
        expect_idle("s8000");

        // Reset while the LO word is pending: LO is dropped
        accept("rstlo", 16'h1234, 1'b0);
        expect_word("rstlo.hi", K_HI, 13'h0012, 1'b0);
        check("rstlo.lo_kind", {14'd0, out_kind_o}, {14'd0, K_LO});
        out_ready_i = 1'b0;
        reset_i     = 1'b1;
        @(negedge clk_i);
        reset_i     = 1'b0;
        out_ready_i = 1'b1;
        expect_idle("rstlo");
        check("rstlo.kind",  {14'd0, out_kind_o}, 16'd0);
        check("rstlo.field", {3'd0, out_field_o}, 16'd0);
        @(negedge clk_i);
        expect_idle("rstlo.after");

`ifdef IMM_ENC_STATS_EN
        // Saturating counters and synchronous clear
        for (int i = 0; i < 300; i++) begin
            in_valid_i     = 1'b1;
            in_value_i     = 16'h4000;
            in_is_branch_i = 1'b0;
            @(negedge clk_i);
            in_valid_i = 1'b0;
            repeat (2) @(negedge clk_i);
        end
        for (int i = 0; i < 2; i++) begin
            in_valid_i     = 1'b1;
            in_value_i     = 16'h0001;
            in_is_branch_i = 1'b1;
            @(negedge clk_i);
            in_valid_i = 1'b0;
            @(negedge clk_i);
        end
        check("stat.split", {8'd0, stat_split_o}, 16'h00FF);
        check("stat.err",   {8'd0, stat_err_o},   16'h0002);
        stat_clr_i = 1'b1;
        @(negedge clk_i);
        stat_clr_i = 1'b0;
        check("stat.split_clr", {8'd0, stat_split_o}, 16'h0000);
        check("stat.err_clr",   {8'd0, stat_err_o},   16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_imm_field_encoder
